// File: rtl/anim_pkg.sv
// Shared types and constants for the LED animation sequencer.
package anim_pkg;

    typedef enum logic [1:0] {WALK, BOUNCE, COUNT, BAR} pattern_t;
    typedef enum logic [1:0] {LOAD, RUN, PAUSE, SWITCH} state_t;

    typedef struct packed {
        logic [7:0] frame;
        logic       down;
    } frame_step_t;

    localparam logic [7:0] INIT_WALK   = 8'h01;
    localparam logic [7:0] INIT_BOUNCE = 8'h01;
    localparam logic [7:0] INIT_COUNT  = 8'h00;
    localparam logic [7:0] INIT_BAR    = 8'h00;

    localparam int SW_PAT_LO   = 0;
    localparam int SW_PAUSE    = 2;
    localparam int SW_DIR      = 3;
    localparam int SW_SPEED_LO = 4;

    function automatic logic [7:0] init_frame(pattern_t p);
        logic [7:0] f;
        case (p)
            WALK:    f = INIT_WALK;
            BOUNCE:  f = INIT_BOUNCE;
            COUNT:   f = INIT_COUNT;
            default: f = INIT_BAR;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: pulses tick on the last count of each TICK_DIV window while enabled.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_anim_sequencer.sv
// LED animation frame sequencer: synchronises switches, runs the pattern FSM, steps frames.
// Handshake: none; frame_strobe is a one-cycle pulse aligned with each new leds value.
module led_anim_sequencer
    import anim_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    output logic [7:0] leds,
    output logic       frame_strobe,
    output logic       paused,
    output state_t     fsm_state
);

    logic [7:0]  sw_m, sw_s;
    state_t      state, state_nx;
    pattern_t    pat, sel_pat;
    logic        bounce_down;
    logic [3:0]  tick_cnt, speed;
    logic        dir, pause_req;
    logic        tick, advance, pres_clr, pres_en;
    frame_step_t step;

    assign sel_pat   = pattern_t'(sw_s[SW_PAT_LO +: 2]);
    assign speed     = sw_s[SW_SPEED_LO +: 4];
    assign dir       = sw_s[SW_DIR];
    assign pause_req = sw_s[SW_PAUSE];

    function automatic frame_step_t next_frame(pattern_t p, logic [7:0] cur, logic d, logic down);
        frame_step_t r;
        r.frame = cur;
        r.down  = down;
        case (p)
            WALK:   r.frame = d ? {cur[0], cur[7:1]} : {cur[6:0], cur[7]};
            BOUNCE: begin
                // Turn around on the endpoint so 80 and 01 show once per sweep.
                if (!down) begin
                    if (cur == 8'h80) begin
                        r.frame = 8'h40;
                        r.down  = 1'b1;
                    end else begin
                        r.frame = cur << 1;
                    end
                end else if (cur == 8'h01) begin
                    r.frame = 8'h02;
                    r.down  = 1'b0;
                end else begin
                    r.frame = cur >> 1;
                end
            end
            COUNT:  r.frame = d ? cur - 8'd1 : cur + 8'd1;
            BAR:    r.frame = (cur == 8'hFF) ? 8'h00 : {cur[6:0], 1'b1};
            default: ;
        endcase
        return r;
    endfunction

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pres_clr),
        .en    (pres_en),
        .tick  (tick)
    );

    always_comb begin
        state_nx = state;
        pres_clr = 1'b0;
        pres_en  = 1'b0;
        case (state)
            LOAD: begin
                pres_clr = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                pres_en = 1'b1;
                if (sel_pat != pat)  state_nx = SWITCH;
                else if (pause_req)  state_nx = PAUSE;
            end
            PAUSE: begin
                if (sel_pat != pat)  state_nx = SWITCH;
                else if (!pause_req) state_nx = RUN;
            end
            SWITCH:  state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Speed is compared live, so lowering S below the current count advances on the next tick.
    assign advance   = (state == RUN) && tick && (tick_cnt >= speed);
    assign step      = next_frame(pat, leds, dir, bounce_down);
    assign paused    = (state == PAUSE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_m         <= 8'h00;
            sw_s         <= 8'h00;
            state        <= LOAD;
            pat          <= WALK;
            bounce_down  <= 1'b0;
            tick_cnt     <= 4'd0;
            leds         <= 8'h00;
            frame_strobe <= 1'b0;
        end else begin
            sw_m         <= sw;
            sw_s         <= sw_m;
            state        <= state_nx;
            frame_strobe <= 1'b0;
            case (state)
                LOAD: begin
                    leds         <= init_frame(sel_pat);
                    pat          <= sel_pat;
                    bounce_down  <= 1'b0;
                    tick_cnt     <= 4'd0;
                    frame_strobe <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
                        leds         <= step.frame;
                        bounce_down  <= step.down;
                        tick_cnt     <= 4'd0;
                        frame_strobe <= 1'b1;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                SWITCH:  leds <= 8'h00;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_anim_sequencer.sv
// Directed and randomized switch scenarios checked cycle by cycle against a frame-index reference model.
module tb_led_anim_sequencer;

    localparam int TD = 2;
    localparam int PH_LOAD   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_PAUSE  = 2;
    localparam int PH_SWITCH = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [7:0] leds;
    logic       frame_strobe;
    logic       paused;
    anim_pkg::state_t fsm_state;

    int errors = 0;
    int checks = 0;

    // Reference model: frames come from a pattern index, timing from elapsed running cycles.
    logic [7:0] s1, s2;
    int         phase, pat, pos, act, ticks;
    logic [7:0] exp_leds;
    logic       exp_strobe;

    led_anim_sequencer #(.TICK_DIV(TD)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .leds         (leds),
        .frame_strobe (frame_strobe),
        .paused       (paused),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] frame_of(int p, int q);
        int k;
        logic [7:0] one;
        one = 8'd1;
        case (p)
            0: begin
                k = ((q % 8) + 8) % 8;
                return one << k;
            end
            1: begin
                k = q % 14;
                return (k < 8) ? (one << k) : (one << (14 - k));
            end
            2: return 8'(((q % 256) + 256) % 256);
            default: begin
                k = q % 9;
                return 8'((1 << k) - 1);
            end
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [7:0] v);
        logic [7:0] ss;
        ss = s2;
        if (r) begin
            s1 = 8'h00; s2 = 8'h00;
            phase = PH_LOAD; pat = 0; pos = 0; act = 0; ticks = 0;
            exp_leds = 8'h00; exp_strobe = 1'b0;
        end else begin
            exp_strobe = 1'b0;
            case (phase)
                PH_LOAD: begin
                    pat = int'(ss[1:0]); pos = 0; act = 0; ticks = 0;
                    exp_leds = frame_of(pat, pos);
                    exp_strobe = 1'b1;
                    phase = PH_RUN;
                end
                PH_RUN: begin
                    if ((act + 1) % TD == 0) begin
                        if (ticks >= int'(ss[7:4])) begin
                            ticks = 0;
                            if ((pat == 0 || pat == 2) && ss[3]) pos = pos - 1;
                            else pos = pos + 1;
                            exp_leds = frame_of(pat, pos);
                            exp_strobe = 1'b1;
                        end else begin
                            ticks = ticks + 1;
                        end
                    end
                    act = act + 1;
                    if (int'(ss[1:0]) != pat) phase = PH_SWITCH;
                    else if (ss[2])           phase = PH_PAUSE;
                end
                PH_PAUSE: begin
                    if (int'(ss[1:0]) != pat) phase = PH_SWITCH;
                    else if (!ss[2])          phase = PH_RUN;
                end
                default: begin
                    exp_leds = 8'h00;
                    phase = PH_LOAD;
                end
            endcase
            s2 = s1;
            s1 = v;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(reset, sw);
        #1;
        check("leds", leds, exp_leds);
        check("frame_strobe", {7'd0, frame_strobe}, {7'd0, exp_strobe});
        check("paused", {7'd0, paused}, {7'd0, (phase == PH_PAUSE)});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        s1 = 8'h00; s2 = 8'h00;
        phase = PH_LOAD; pat = 0; pos = 0; act = 0; ticks = 0;
        exp_leds = 8'h00; exp_strobe = 1'b0;

        // reset then WALK forward at the fastest speed
        reset = 1'b1; sw = 8'h00;
        run(2);
        reset = 1'b0;
        run(40);

        // BOUNCE across two full sweeps
        sw = 8'h01;
        run(70);

        // COUNT reverse, S=3
        sw = 8'h3A;
        run(80);

        // pause mid-period, then release
        run(3);
        sw = 8'h3E;
        run(20);
        sw = 8'h3A;
        run(30);

        // WALK, then BAR with pause arriving on the same edge
        sw = 8'h00;
        run(20);
        sw = 8'h07;
        run(12);
        sw = 8'h03;
        run(30);

        // reset while paused
        sw = 8'h06;
        run(15);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(20);
        sw = 8'h02;
        run(40);

        // randomized switch settings, including mid-period speed/direction changes
        for (int seg = 0; seg < 50; seg++) begin
            sw[1:0] = 2'($urandom_range(0, 3));
            sw[2]   = ($urandom_range(0, 4) == 0);
            sw[3]   = 1'($urandom_range(0, 1));
            sw[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 3));
                reset = 1'b0;
            end
            run($urandom_range(1, 60));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
